// File: rtl/edabk_receiver.sv
// edabk_receiver: oversampling UART receive stage (start, LSB-first data, optional parity, stop, break hold-off).
// Build option: define EDABK_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling of every bit.
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver #(
    parameter int DATA_WIDTH = `CFG_DATA_WIDTH,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  full,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun_err,
    output logic                  busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [TW-1:0] BIT_PT = TW'(OVERSAMPLE - 1);
`ifdef EDABK_RX_MAJORITY_VOTE_EN
    // The vote window ends one tick later, so every bit decision shifts by one tick.
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] START_PT = TW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

`ifdef EDABK_RX_MAJORITY_VOTE_EN
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
`endif

    logic                  rx_meta_r;
    logic                  rx_sync_r;
    state_t                state_r;
    state_t                state_s;
    logic [TW-1:0]         tick_cnt_r;
    logic [BW-1:0]         bit_cnt_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_en_r;
    logic                  par_odd_r;
    logic                  perr_r;
    logic [TW-1:0]         point_s;
    logic                  at_point_s;
    logic                  bit_val_s;
    logic                  last_bit_s;
    logic                  valid_s;
    logic                  ovr_s;
    logic                  ferr_s;
    logic                  perr_out_s;
    logic                  busy_s;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

`ifdef EDABK_RX_MAJORITY_VOTE_EN
    logic [1:0] vote_r;

    // History of the two previous tick samples for the 2-of-3 vote.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vote_r <= 2'b11;
        end else if (sample_tick) begin
            vote_r <= {vote_r[0], rx_sync_r};
        end
    end

    assign bit_val_s = majority3(vote_r[1], vote_r[0], rx_sync_r);
`else
    assign bit_val_s = rx_sync_r;
`endif

    assign point_s    = (state_r == ST_START) ? START_PT : BIT_PT;
    assign at_point_s = sample_tick && (tick_cnt_r == point_s);
    assign last_bit_s = (bit_cnt_r == LAST_BIT);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_tick && !rx_sync_r) state_s = ST_START;
                else                           state_s = ST_IDLE;
            end
            ST_START: begin
                if (at_point_s) state_s = bit_val_s ? ST_IDLE : ST_DATA;
                else            state_s = ST_START;
            end
            ST_DATA: begin
                if (at_point_s && last_bit_s) state_s = par_en_r ? ST_PARITY : ST_STOP;
                else                          state_s = ST_DATA;
            end
            ST_PARITY: begin
                if (at_point_s) state_s = ST_STOP;
                else            state_s = ST_PARITY;
            end
            ST_STOP: begin
                if (at_point_s) state_s = bit_val_s ? ST_IDLE : ST_BREAK;
                else            state_s = ST_STOP;
            end
            ST_BREAK: begin
                if (rx_sync_r) state_s = ST_IDLE;
                else           state_s = ST_BREAK;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; busy is held low in the frame_err cycle so no pulse ever overlaps busy.
    always_comb begin
        valid_s    = 1'b0;
        ovr_s      = 1'b0;
        ferr_s     = 1'b0;
        perr_out_s = 1'b0;
        if ((state_r == ST_STOP) && at_point_s) begin
            valid_s    = bit_val_s & ~full;
            ovr_s      = bit_val_s & full;
            ferr_s     = ~bit_val_s;
            perr_out_s = bit_val_s & perr_r;
        end else begin
            valid_s    = 1'b0;
            ovr_s      = 1'b0;
            ferr_s     = 1'b0;
            perr_out_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE) && !ferr_s;
    end

    // Tick/bit counters, shift register and latched frame configuration; all stall without sample_tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_r <= TW'(0);
            bit_cnt_r  <= BW'(0);
            shift_r    <= DATA_WIDTH'(0);
            par_en_r   <= 1'b0;
            par_odd_r  <= 1'b0;
            perr_r     <= 1'b0;
        end else if (sample_tick) begin
            case (state_r)
                ST_IDLE: begin
                    tick_cnt_r <= TW'(0);
                    if (!rx_sync_r) begin
                        par_en_r  <= parity_en;
                        par_odd_r <= parity_odd;
                        perr_r    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (at_point_s) begin
                        tick_cnt_r <= TW'(0);
                        bit_cnt_r  <= BW'(0);
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                ST_DATA: begin
                    if (at_point_s) begin
                        shift_r[bit_cnt_r[BW-2:0]] <= bit_val_s;
                        bit_cnt_r  <= bit_cnt_r + BW'(1);
                        tick_cnt_r <= TW'(0);
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                ST_PARITY: begin
                    if (at_point_s) begin
                        perr_r     <= (calc_parity(shift_r) ^ bit_val_s) != par_odd_r;
                        tick_cnt_r <= TW'(0);
                    end else begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                ST_STOP: begin
                    if (at_point_s) tick_cnt_r <= TW'(0);
                    else            tick_cnt_r <= tick_cnt_r + TW'(1);
                end
                default: tick_cnt_r <= TW'(0);
            endcase
        end
    end

    // Registered outputs: one-cycle pulses and the held receive byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data     <= DATA_WIDTH'(0);
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (valid_s) rx_data <= shift_r;
            rx_valid    <= valid_s;
            parity_err  <= perr_out_s;
            frame_err   <= ferr_s;
            overrun_err <= ovr_s;
            busy        <= busy_s;
        end
    end

endmodule

// File: tb/tb_edabk_receiver.sv
// Self-checking bench for edabk_receiver: frame-level scoreboard plus directed literal checks.
module tb_edabk_receiver;
    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       parity_en;
    logic       parity_odd;
    logic       full;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int div    = 1;
    int n_valid = 0, n_ovr = 0, n_ferr = 0, n_perr = 0;
    logic [7:0] model_data = 8'h00;

`ifdef EDABK_RX_MAJORITY_VOTE_EN
    localparam bit MAJ = 1'b1;
    localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
    localparam bit MAJ = 1'b0;
    localparam logic [7:0] GLITCH_EXP = 8'h08;
`endif

    // kind: 0 = rx_valid, 1 = overrun_err, 2 = frame_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       perr;
    } exp_t;
    exp_t exp_q[$];

    edabk_receiver #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .reset(reset), .sample_tick(sample_tick),
        .parity_en(parity_en), .parity_odd(parity_odd), .full(full), .rx_in(rx_in),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    initial begin : tick_gen
        int cnt;
        cnt = 0;
        sample_tick = 1'b1;
        forever begin
            @(negedge clk);
            cnt = (cnt + 1) % div;
            sample_tick = (cnt == 0);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one frame bit by bit; expectation derived from the frame-level rules.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic podd,
                              input logic pbit, input logic stop, input logic full_in,
                              input int glitch_bit, input int abort_bit);
        exp_t e;
        int   nbits;
        int   bclks;
        int   lim;
        logic b;
        nbits = pen ? 11 : 10;
        bclks = 16 * div;
        if (abort_bit < 0) begin
            e.kind = (stop == 1'b0) ? 2 : (full_in ? 1 : 0);
            e.data = (glitch_bit >= 0 && !MAJ) ? (d ^ (8'h01 << glitch_bit)) : d;
            e.perr = (stop && pen) ? ((^d ^ pbit) != podd) : 1'b0;
            exp_q.push_back(e);
        end
        parity_en  = pen;
        parity_odd = podd;
        full       = full_in;
        for (int i = 0; i < nbits; i++) begin
            if (i == 0)              b = 1'b0;
            else if (i <= 8)         b = d[i-1];
            else if (pen && i == 9)  b = pbit;
            else                     b = stop;
            if (i == 1) begin
                parity_en  = ~pen;
                parity_odd = ~podd;
            end
            lim = (abort_bit >= 0 && i == abort_bit + 1) ? bclks / 2 : bclks;
            for (int c = 0; c < lim; c++) begin
                rx_in = (glitch_bit >= 0 && i == glitch_bit + 1 && c == 8) ? ~b : b;
                @(negedge clk);
            end
            if (abort_bit >= 0 && i == abort_bit + 1) return;
        end
        parity_en  = pen;
        parity_odd = podd;
    endtask

    task automatic drain(input int max_cyc);
        for (int k = 0; k < max_cyc && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_timeout", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    initial begin : compare
        exp_t e;
        int   dk;
        forever begin
            @(negedge clk);
            if (reset == 1'b0) begin
                if (rx_valid || overrun_err || frame_err) begin
                    n_valid += int'(rx_valid);
                    n_ovr   += int'(overrun_err);
                    n_ferr  += int'(frame_err);
                    n_perr  += int'(parity_err);
                    chk("pulse_exclusive", int'(rx_valid) + int'(overrun_err) + int'(frame_err), 1);
                    chk("busy_at_pulse", int'(busy), 0);
                    dk = rx_valid ? 0 : (overrun_err ? 1 : 2);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", dk + 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pulse_kind", dk, e.kind);
                        chk("parity_err", int'(parity_err), int'(e.perr));
                        if (e.kind == 0) model_data = e.data;
                    end
                end else begin
                    chk("stray_parity_err", int'(parity_err), 0);
                end
                chk("rx_data_model", int'(rx_data), int'(model_data));
            end
        end
    end

    initial begin : main
        int v0, o0, f0, p0;
        reset = 1'b1; rx_in = 1'b1; full = 1'b0; parity_en = 1'b0; parity_odd = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", int'(rx_data), 0);
        chk("reset_rx_valid", int'(rx_valid), 0);
        chk("reset_errs", int'({parity_err, frame_err, overrun_err}), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 1: plain frame
        v0 = n_valid; o0 = n_ovr; f0 = n_ferr; p0 = n_perr;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t1_data", int'(rx_data), 32'hA5);
        chk("t1_valid_cnt", n_valid - v0, 1);
        chk("t1_err_cnt", (n_ovr - o0) + (n_ferr - f0) + (n_perr - p0), 0);

        // 2: even parity good then bad, odd parity good
        v0 = n_valid; p0 = n_perr;
        send_frame(8'hAB, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t2_data", int'(rx_data), 32'hAB);
        chk("t2_perr_good", n_perr - p0, 0);
        send_frame(8'hAB, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t2_perr_bad", n_perr - p0, 1);
        send_frame(8'hAB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t2_perr_odd", n_perr - p0, 1);
        chk("t2_valid_cnt", n_valid - v0, 3);

        // 3: stop bit low, then line held low
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
        repeat (100) @(negedge clk);
        chk("t3_ferr_cnt", n_ferr - f0, 1);
        chk("t3_valid_cnt", n_valid - v0, 0);
        chk("t3_busy_break", int'(busy), 1);
        chk("t3_data_held", int'(rx_data), 32'hAB);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("t3_busy_idle", int'(busy), 0);

        // 4: short low pulse is a false start
        v0 = n_valid;
        rx_in = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_busy_start", int'(busy), 1);
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (30) @(negedge clk);
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_valid_cnt", n_valid - v0, 0);

        // 4b: one-clock glitch at mid-bit of bit 3
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, -1);
        drain(300);
        chk("t4_glitch_data", int'(rx_data), int'(GLITCH_EXP));

        // 5: overrun, then back-to-back frames
        v0 = n_valid; o0 = n_ovr;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, -1);
        drain(300);
        full = 1'b0;
        chk("t5_ovr_cnt", n_ovr - o0, 1);
        chk("t5_valid_cnt", n_valid - v0, 0);
        chk("t5_data_held", int'(rx_data), int'(GLITCH_EXP));
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t5_b2b_cnt", n_valid - v0, 2);
        chk("t5_b2b_data", int'(rx_data), 32'h80);

        // 6: reset mid-frame, clean frame, then slow ticks
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, 4);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_data", int'(rx_data), 0);
        chk("t6_rst_pulses", int'({rx_valid, parity_err, frame_err, overrun_err}), 0);
        model_data = 8'h00;
        exp_q.delete();
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        #3;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        v0 = n_valid;
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(300);
        chk("t6_clean_data", int'(rx_data), 32'h7E);
        div = 4;
        repeat (8) @(negedge clk);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
        drain(1200);
        chk("t6_slow_data", int'(rx_data), 32'h7E);
        chk("t6_valid_cnt", n_valid - v0, 2);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
